// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings, forwarding selects and the MD sequencer state type.
package hazard_pkg;
  localparam logic [1:0] WB_ALU = 2'b00, WB_PC4 = 2'b01, WB_MEM = 2'b10, WB_IMM = 2'b11;
  localparam logic [1:0] FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  // M beats W so the youngest producer wins; x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wm, input logic [4:0] ww,
                                         input logic rwm, input logic rww);
    return (rwm && wm != 5'd0 && wm == src) ? FWD_M : (rww && ww != 5'd0 && ww == src) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/md_seq.sv
// md_seq: multiply/divide sequencer; holds the op in EX for MD_LAT stall cycles plus one release cycle.
module md_seq import hazard_pkg::*; #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_op,
  output logic md_start,
  output logic md_busy,
  output logic md_stall
);
  localparam int CW = $clog2(MD_LAT + 1);
  md_state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else case (state)
      IDLE: if (md_op) begin
        state <= BUSY;
        cnt   <= CW'(MD_LAT - 1);
      end
      BUSY: begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= DONE;
      end
      default: state <= IDLE;
    endcase
  assign md_start = state == IDLE && md_op;
  assign md_stall = md_start || state == BUSY;
  assign md_busy  = state != IDLE;
endmodule

// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: stall/flush/forward control for the 5-stage pipeline; HAZ_FWD_EN selects forwarding vs RAW stalls.
module md_hazard_ctrl import hazard_pkg::*; #(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] raddr1D,
  input  logic [4:0] raddr2D,
  input  logic [4:0] raddr1E,
  input  logic [4:0] raddr2E,
  input  logic [4:0] waddrE,
  input  logic [4:0] waddrM,
  input  logic [4:0] waddrW,
  input  logic       reg_wrE,
  input  logic       reg_wrM,
  input  logic       reg_wrW,
  input  logic [1:0] wb_selE,
  input  logic       md_opE,
  input  logic       br_takenE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] fwd_AE,
  output logic [1:0] fwd_BE,
  output logic       md_start,
  output logic       md_busy
);
  logic md_stall, md_start_i, md_busy_i, lw_stall, haz;
  md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
    .clk(clk), .rst(rst), .md_op(md_opE),
    .md_start(md_start_i), .md_busy(md_busy_i), .md_stall(md_stall)
  );
  assign lw_stall = wb_selE == WB_MEM && waddrE != 5'd0 && (waddrE == raddr1D || waddrE == raddr2D);
`ifdef HAZ_FWD_EN
  logic unused_fwd;
  assign unused_fwd = reg_wrE;
  assign haz    = lw_stall;
  assign fwd_AE = rst ? FWD_RF : fwd_sel(raddr1E, waddrM, waddrW, reg_wrM, reg_wrW);
  assign fwd_BE = rst ? FWD_RF : fwd_sel(raddr2E, waddrM, waddrW, reg_wrM, reg_wrW);
`else
  // W-stage writes are bypassed inside the register file, so only E and M producers stall
  function automatic logic raw_hit(input logic [4:0] s);
    return s != 5'd0 && ((reg_wrE && waddrE == s) || (reg_wrM && waddrM == s));
  endfunction
  logic unused_fwd;
  assign unused_fwd = ^{raddr1E, raddr2E, waddrW, reg_wrW};
  assign haz    = lw_stall || raw_hit(raddr1D) || raw_hit(raddr2D);
  assign fwd_AE = FWD_RF;
  assign fwd_BE = FWD_RF;
`endif
  assign StallF   = !rst && (md_stall || (!br_takenE && haz));
  assign StallD   = StallF;
  assign StallE   = !rst && md_stall;
  assign FlushD   = !rst && !md_stall && br_takenE;
  assign FlushE   = !rst && !md_stall && (br_takenE || haz);
  assign FlushM   = StallE;
  assign md_start = !rst && md_start_i;
  assign md_busy  = !rst && md_busy_i;
endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb_md_hazard_ctrl: directed checks of forwarding, load-use, branch priority, RAW and MD sequencing.
module tb_md_hazard_ctrl;
`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [7:0] S = 8'b1110_0110, B = 8'b1110_0101, D = 8'b0000_0001;
  localparam logic [7:0] LW = 8'b1100_1000, BR = 8'b0001_1000;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] raddr1D, raddr2D, raddr1E, raddr2E, waddrE, waddrM, waddrW;
  logic reg_wrE, reg_wrM, reg_wrW, md_opE, br_takenE;
  logic [1:0] wb_selE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, md_start, md_busy;
  logic [1:0] fwd_AE, fwd_BE;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  md_hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
    .waddrE(waddrE), .waddrM(waddrM), .waddrW(waddrW), .reg_wrE(reg_wrE), .reg_wrM(reg_wrM),
    .reg_wrW(reg_wrW), .wb_selE(wb_selE), .md_opE(md_opE), .br_takenE(br_takenE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .fwd_AE(fwd_AE), .fwd_BE(fwd_BE), .md_start(md_start), .md_busy(md_busy)
  );
  wire [7:0] ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, md_start, md_busy};
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic clear;
    {raddr1D, raddr2D, raddr1E, raddr2E, waddrE, waddrM, waddrW} = '0;
    {reg_wrE, reg_wrM, reg_wrW, md_opE, br_takenE} = '0;
    wb_selE = 2'b00;
  endtask
  task automatic set_lw;
    wb_selE = 2'b10; waddrE = 5'd7; raddr1D = 5'd7;
  endtask
  initial begin
    logic [7:0] exp_md [5] = '{S, B, B, B, 8'b1100_1001};
    logic [7:0] exp_b2b [10] = '{S, B, B, B, D, S, B, B, B, D};
    int stalls, starts;
    clear;
    md_opE = 1'b1; br_takenE = 1'b1; set_lw; reg_wrM = 1'b1; waddrM = 5'd5; raddr1E = 5'd5;
    #1 check("rst_ctl", ctl, 8'h00);
    check("rst_fwd", {4'b0, fwd_AE, fwd_BE}, 8'h00);
    @(negedge clk); clear; rst = 1'b0; #1 check("post_rst", ctl, 8'h00);
    @(negedge clk); reg_wrM = 1'b1; waddrM = 5'd5; raddr1E = 5'd5; reg_wrW = 1'b1; waddrW = 5'd5;
    #1 check("fwd_m", {6'b0, fwd_AE}, FWD ? 8'd2 : 8'd0);
    check("fwd_ctl", ctl, 8'h00);
    @(negedge clk); waddrM = 5'd0; raddr2E = 5'd5;
    #1 check("fwd_w_a", {6'b0, fwd_AE}, FWD ? 8'd1 : 8'd0);
    check("fwd_w_b", {6'b0, fwd_BE}, FWD ? 8'd1 : 8'd0);
    @(negedge clk); reg_wrW = 1'b0; #1 check("fwd_none", {4'b0, fwd_AE, fwd_BE}, 8'h00);
    @(negedge clk); clear; wb_selE = 2'b10; waddrE = 5'd7; raddr2D = 5'd7; reg_wrE = 1'b1;
    #1 check("lw_stall", ctl, LW);
    @(negedge clk); wb_selE = 2'b00; reg_wrE = 1'b0; waddrE = 5'd0; #1 check("lw_gone", ctl, 8'h00);
    @(negedge clk); wb_selE = 2'b10; #1 check("lw_x0", ctl, 8'h00);
    @(negedge clk); waddrE = 5'd7; br_takenE = 1'b1; #1 check("br_prio", ctl, BR);
    @(negedge clk); clear; reg_wrM = 1'b1; waddrM = 5'd3; raddr1D = 5'd3;
    #1 check("raw_m", ctl, FWD ? 8'h00 : LW);
    @(negedge clk); reg_wrM = 1'b0; #1 check("raw_off", ctl, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clear; md_opE = 1'b1;
      if (i >= 2) set_lw;
      #1 check($sformatf("md%0d", i), ctl, exp_md[i]);
    end
    @(negedge clk); clear; #1 check("md_idle", ctl, 8'h00);
    stalls = 0; starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); md_opE = 1'b1;
      #1 check($sformatf("b2b%0d", i), ctl, exp_b2b[i]);
      stalls += int'(StallE); starts += int'(md_start);
    end
    check("b2b_stalls", 8'(stalls), 8'd8);
    check("b2b_starts", 8'(starts), 8'd2);
    @(negedge clk); clear; #1 check("b2b_idle", ctl, 8'h00);
    @(negedge clk); md_opE = 1'b1; #1 check("rm_start", ctl, S);
    @(negedge clk); #1 check("rm_busy", ctl, B);
    @(negedge clk); rst = 1'b1; #1 check("rm_rst", ctl, 8'h00);
    @(negedge clk); rst = 1'b0; md_opE = 1'b0; #1 check("rm_idle", ctl, 8'h00);
    @(negedge clk); md_opE = 1'b1; #1 check("rm_restart", ctl, S);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); #1 check($sformatf("rm%0d", i), ctl, i == 4 ? D : B);
    end
    @(negedge clk); clear; #1 check("end_idle", ctl, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_hazard_ctrl.md
# md_hazard_ctrl

Hazard and sequencing controller for the RV32IM 5-stage pipeline. Generates the stall, flush and forwarding controls for the IF/ID, ID/EX and EX/MEM pipeline registers. Sequences the multi-cycle M-extension multiply/divide unit in EX by holding the ID/EX register and injecting bubbles into MEM until the result is ready. Sits beside the datapath, fed by register addresses and control bits from the D, E, M and W stages.

## Interface
- MD_LAT, 4: EX cycles the M-extension unit needs per operation (>= 2).
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- raddr1D, raddr2D  in  5 each  source registers in D.
- raddr1E, raddr2E, waddrE  in  5 each  source and destination registers in E.
- waddrM, waddrW  in  5 each  destination registers in M and W.
- reg_wrE, reg_wrM, reg_wrW  in  1 each  register write enables per stage.
- wb_selE  in  2  write-back select in E; WB_MEM (2'b10) marks a load.
- md_opE  in  1  the instruction in E is a MUL/DIV/REM.
- br_takenE  in  1  branch/jump resolved taken in E.
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID and ID/EX.
- FlushD, FlushE, FlushM  out  1 each  bubble IF/ID, ID/EX and EX/MEM (NOP 32'h00000013).
- fwd_AE, fwd_BE  out  2 each  ALU operand source: 00 register file, 01 W result, 10 M result.
- md_start  out  1  one-cycle start pulse to the multiply/divide unit.
- md_busy  out  1  registered; unit is mid-operation.

## Operation
- Forwarding, per operand: 10 if reg_wrM && waddrM!=0 && waddrM==raddrXE; else 01 if reg_wrW && waddrW!=0 && waddrW==raddrXE; else 00. M has priority over W.
- Load-use: lw_stall = (wb_selE==WB_MEM) && waddrE!=0 && (waddrE==raddr1D || waddrE==raddr2D). Asserts StallF, StallD and FlushE.
- Branch: br_takenE asserts FlushD and FlushE.
- MD sequencer FSM (IDLE, BUSY, DONE) with counter cnt:
  - IDLE: if md_opE, pulse md_start, set md_stall=1, load cnt=MD_LAT-1, go to BUSY.
  - BUSY: md_stall=1 and cnt decrements. When cnt==1, go to DONE.
  - DONE: md_stall=0 and the instruction advances to M on this edge. Go to IDLE unconditionally. DONE is never re-triggered by the same md_opE.
  - md_stall asserts StallF, StallD, StallE and FlushM.
  - Total: MD_LAT stall cycles, so the MD op occupies E for MD_LAT+1 cycles.
  - Back-to-back MD ops restart from IDLE on the next instruction.
- Priority: rst > md_stall > br_takenE > lw_stall.
  - While md_stall is active, lw_stall is ignored. It is re-evaluated after the stall.
  - FlushE and StallE are never asserted together.
- md_busy = (state != IDLE).

## Timing
- Forwarding, stall, flush and md_start are combinational from inputs and state. They are valid in the same cycle.
- FSM state and cnt update on posedge clk.
- While rst=1: all outputs are 0 and fwd_AE/fwd_BE are 00. On the next edge, state=IDLE, cnt=0, md_busy=0.
- Reset mid-operation aborts the sequence. md_start is not reissued unless md_opE is high after reset.
- x0 never creates a hazard or a forward.

## Configuration
- HAZ_FWD_EN defined: forwarding as above. Only load-use and MD stalls occur.
- HAZ_FWD_EN undefined:
  - fwd_AE and fwd_BE are tied to 00.
  - raw_stall = a D source (nonzero) matches waddrE (reg_wrE) or waddrM (reg_wrM).
  - raw_stall asserts StallF, StallD and FlushE, with the same priority as lw_stall.
  - The register file resolves W-stage writes internally.

## Structure
- Package hazard_pkg holds:
  - WB_MEM and the other wb_sel encodings.
  - FWD_RF, FWD_W and FWD_M constants.
  - The md_state_t enum {IDLE, BUSY, DONE}.
- Sub-module md_seq holds the FSM, the counter, md_start, md_busy and md_stall. The top holds the hazard logic and output combination.

## Test plan
- Forwarding: reg_wrM=1, waddrM=5, raddr1E=5, plus reg_wrW=1, waddrW=5 -> fwd_AE=10. Then waddrM=0 -> fwd_AE=01.
- Load-use: wb_selE=10, waddrE=7, raddr2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. With waddrE=0 -> no stall.
- MD sequence, MD_LAT=4: md_opE rises -> md_start is high for 1 cycle. StallE and FlushM are high for exactly 4 cycles, then low in the DONE cycle. md_busy is high for 4 cycles after the first edge.
- Back-to-back MD ops: two MUL in consecutive instructions -> two md_start pulses 5 cycles apart, 8 stall cycles total.
- Reset mid-op: rst asserted in the 2nd BUSY cycle -> all outputs 0 while rst is high. md_busy=0 after the edge, and a fresh md_start follows once md_opE is seen.
- Priority: br_takenE=1 together with lw_stall conditions -> FlushD=FlushE=1 and StallF=StallD=0. With HAZ_FWD_EN undefined, waddrM=3, raddr1D=3 -> raw stall.
